// File: rtl/instr_sequencer_pkg.sv
// cpu_pkg: shared definitions for the instruction sequencer and its neighbours.
// Holds the datapath widths, opcode constants, the sequencer state enumeration
// and small helpers for pulling fields out of an instruction word.
package cpu_pkg;

  localparam int INSTR_W   = 32;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int OPC_W     = 5;
  localparam int OPC_LSB   = 27;
  localparam int DADDR_LSB = 11;

  localparam logic [OPC_W-1:0] OPC_NOP  = 5'd0;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'd16;
  localparam logic [OPC_W-1:0] OPC_JMP  = 5'd17;
  localparam logic [OPC_W-1:0] OPC_BZ   = 5'd18;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

  // Data-memory address field used by LD.
  function automatic logic [ADDR_W-1:0] daddr_of(input logic [INSTR_W-1:0] instr);
    return instr[DADDR_LSB +: ADDR_W];
  endfunction

  // True for opcodes that the decoder commits directly in EXEC:
  // NOP, the register/ALU group and the unused codes that behave as NOP.
  function automatic logic commits_in_exec(input logic [OPC_W-1:0] opc);
    return (opc <= 5'd15) || ((opc >= 5'd19) && (opc <= 5'd30));
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction- and data-memory handshake bundle.
//   imem_req/imem_addr -> instruction memory, imem_ack/imem_rdata <- reply
//   dmem_req/dmem_addr -> data memory,        dmem_ack/dmem_rdata <- reply
// master: the sequencer side; slave: the memory side.
interface instr_sequencer_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic [ADDR_W-1:0]  dmem_addr;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_addr,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_addr,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer for a small accumulator CPU.
// Ports:
//   clk, rst_n  - rising-edge clock, synchronous active-low reset
//   run         - level enable; stopping only happens at instruction boundaries
//   zero        - ALU zero flag, sampled in EXEC by BZ
//   mem         - instruction/data memory handshakes (master side)
//   op          - latched instruction word for the external decoder
//   op_valid    - one-cycle commit strobe (EXEC for ALU/NOP, WB for LD)
//   ld_data     - LD result, valid with op_valid in WB
//   pc, halted  - program counter and HALT-reached status
// Every output is a register loaded from the next-state values, so outputs
// change only on clock edges and depend on state alone.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  zero,
  instr_sequencer_if.master     mem,
  output logic [INSTR_W-1:0]    op,
  output logic                  op_valid,
  output logic [DATA_W-1:0]     ld_data,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halted
);

  state_t             state_r,   state_nxt_s;
  logic [ADDR_W-1:0]  pc_r,      pc_nxt_s;
  logic [INSTR_W-1:0] op_r,      op_nxt_s;
  logic [DATA_W-1:0]  ld_data_r, ld_data_nxt_s;
  logic               op_valid_r;
  logic               imem_req_r;
  logic [ADDR_W-1:0]  imem_addr_r;
  logic               dmem_req_r;
  logic [ADDR_W-1:0]  dmem_addr_r;
  logic               halted_r;

  // Next-state and next-datapath decode; acks only matter in their own state.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    op_nxt_s      = op_r;
    ld_data_nxt_s = ld_data_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (mem.imem_ack) begin
          op_nxt_s    = mem.imem_rdata;
          pc_nxt_s    = pc_r + 8'd1;  // wraps 255 -> 0
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (opcode_of(op_r))
          OPC_LD:   state_nxt_s = ST_MEM;
          OPC_HALT: state_nxt_s = ST_HALT;
          OPC_JMP: begin
            pc_nxt_s    = op_r[ADDR_W-1:0];
            state_nxt_s = run ? ST_FETCH : ST_IDLE;
          end
          OPC_BZ: begin
            if (zero) pc_nxt_s = op_r[ADDR_W-1:0];
            else      pc_nxt_s = pc_r;
            state_nxt_s = run ? ST_FETCH : ST_IDLE;
          end
          default:  state_nxt_s = run ? ST_FETCH : ST_IDLE;
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          ld_data_nxt_s = mem.dmem_rdata;
          state_nxt_s   = ST_WB;
        end else begin
          state_nxt_s   = ST_MEM;
        end
      end
      ST_WB: begin
        state_nxt_s = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        if (run) state_nxt_s = ST_HALT;
        else     state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are pre-decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= 8'd0;
      op_r        <= 32'd0;
      ld_data_r   <= 16'd0;
      op_valid_r  <= 1'b0;
      imem_req_r  <= 1'b0;
      imem_addr_r <= 8'd0;
      dmem_req_r  <= 1'b0;
      dmem_addr_r <= 8'd0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      op_r        <= op_nxt_s;
      ld_data_r   <= ld_data_nxt_s;
      op_valid_r  <= ((state_nxt_s == ST_EXEC) && commits_in_exec(opcode_of(op_nxt_s)))
                     || (state_nxt_s == ST_WB);
      imem_req_r  <= (state_nxt_s == ST_FETCH);
      imem_addr_r <= pc_nxt_s;
      dmem_req_r  <= (state_nxt_s == ST_MEM);
      dmem_addr_r <= daddr_of(op_nxt_s);
      halted_r    <= (state_nxt_s == ST_HALT);
    end
  end

  assign op            = op_r;
  assign op_valid      = op_valid_r;
  assign ld_data       = ld_data_r;
  assign pc            = pc_r;
  assign halted        = halted_r;
  assign mem.imem_req  = imem_req_r;
  assign mem.imem_addr = imem_addr_r;
  assign mem.dmem_req  = dmem_req_r;
  assign mem.dmem_addr = dmem_addr_r;

endmodule
